// File: rtl/shift_taps_pkg.sv
// Shared constants and types for the tapped shift register sequencer.
package shift_taps_pkg;

    localparam int WIDTH = 8;
    localparam int DEPTH = 64;
    localparam int FCW   = 7;

    localparam int TAP_ONE_STAGE   = 15;
    localparam int TAP_TWO_STAGE   = 31;
    localparam int TAP_THREE_STAGE = 47;
    localparam int TAP_OUT_STAGE   = 63;

    localparam int WIN_W         = 4 * WIDTH;
    localparam int WIN_ONE_LSB   = 0;
    localparam int WIN_TWO_LSB   = WIDTH;
    localparam int WIN_THREE_LSB = 2 * WIDTH;
    localparam int WIN_OUT_LSB   = 3 * WIDTH;

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

endpackage

// File: rtl/shift_taps_out_reg.sv
// Holding register for the emitted tap window with valid/ready handshake.
module shift_taps_out_reg #(
    parameter int WIN_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIN_W-1:0] win,
    input  logic             out_ready,
    output logic [WIN_W-1:0] out_win,
    output logic             out_valid,
    output logic             slot_free
);

    assign slot_free = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_win   <= '0;
            out_valid <= 1'b0;
        end else if (capture) begin
            out_win   <= win;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/shift_taps_ctrl.sv
// Sequencer for the 8x64 tapped shift register: byte intake, window capture, zero-fill flush.
//   state | meaning
//   IDLE  | accept bytes, count fill, capture windows once full
//   FLUSH | shift zeros for DEPTH cycles, then restart the fill count
module shift_taps_ctrl #(
    parameter int WIDTH = shift_taps_pkg::WIDTH,
    parameter int DEPTH = shift_taps_pkg::DEPTH,
    parameter int FCW   = shift_taps_pkg::FCW
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               flush,
    output logic               busy,
    output logic               sr_shift,
    output logic [WIDTH-1:0]   sr_din,
    input  logic [WIDTH-1:0]   sr_tap_one,
    input  logic [WIDTH-1:0]   sr_tap_two,
    input  logic [WIDTH-1:0]   sr_tap_three,
    input  logic [WIDTH-1:0]   sr_out,
    output logic [4*WIDTH-1:0] out_win,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [FCW-1:0]     fill_count
);
    import shift_taps_pkg::*;

    localparam logic [FCW-1:0] DEPTH_FC   = FCW'(DEPTH);
    localparam logic [FCW-1:0] LAST_FLUSH = FCW'(DEPTH - 1);

    state_t               state, state_nxt;
    logic [FCW-1:0]       fill_nxt;
    logic [FCW-1:0]       flush_cnt, flush_cnt_nxt;
    logic                 pend, pend_nxt;
    logic                 busy_nxt;
    logic                 slot_free;
    logic                 accept;
    logic                 capture;
    logic [4*WIDTH-1:0]   win;

    always_comb begin
        win = '0;
        win[WIN_ONE_LSB   +: WIDTH] = sr_tap_one;
        win[WIN_TWO_LSB   +: WIDTH] = sr_tap_two;
        win[WIN_THREE_LSB +: WIDTH] = sr_tap_three;
        win[WIN_OUT_LSB   +: WIDTH] = sr_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            fill_count <= '0;
            pend       <= 1'b0;
            busy       <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            fill_count <= fill_nxt;
            pend       <= pend_nxt;
            busy       <= busy_nxt;
            flush_cnt  <= flush_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        fill_nxt      = fill_count;
        pend_nxt      = pend;
        busy_nxt      = busy;
        flush_cnt_nxt = flush_cnt;
        in_ready      = 1'b0;
        accept        = 1'b0;
        capture       = 1'b0;
        sr_shift      = 1'b0;
        sr_din        = '0;
        case (state)
            IDLE: begin
                in_ready = !pend || slot_free;
                accept   = in_valid && in_ready;
                capture  = pend && slot_free;
                sr_shift = accept;
                sr_din   = in_data;
                if (capture)
                    pend_nxt = 1'b0;
                // A fresh pend wins over a same-cycle capture clearing the old one.
                if (accept) begin
                    if (fill_count != DEPTH_FC)
                        fill_nxt = fill_count + 1'b1;
                    if (fill_nxt == DEPTH_FC)
                        pend_nxt = 1'b1;
                end
                if (flush && !pend && !accept) begin
                    state_nxt     = FLUSH;
                    busy_nxt      = 1'b1;
                    flush_cnt_nxt = '0;
                end
            end
            FLUSH: begin
                sr_shift      = 1'b1;
                sr_din        = '0;
                flush_cnt_nxt = flush_cnt + 1'b1;
                if (flush_cnt == LAST_FLUSH) begin
                    state_nxt = IDLE;
                    busy_nxt  = 1'b0;
                    fill_nxt  = '0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    shift_taps_out_reg #(
        .WIN_W (4 * WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .capture   (capture),
        .win       (win),
        .out_ready (out_ready),
        .out_win   (out_win),
        .out_valid (out_valid),
        .slot_free (slot_free)
    );

endmodule

// File: tb/tb_shift_taps_ctrl.sv
// Bench for shift_taps_ctrl with a behavioural 8x64 tapped shift register attached.
module tb_shift_taps_ctrl;

    logic        clk;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic        busy;
    logic        sr_shift;
    logic [7:0]  sr_din;
    logic [7:0]  sr_tap_one;
    logic [7:0]  sr_tap_two;
    logic [7:0]  sr_tap_three;
    logic [7:0]  sr_out;
    logic [31:0] out_win;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  fill_count;

    logic [7:0]  sr_mem [64];

    int n_chk;
    int n_fail;

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_ov;
        logic [31:0] exp_win;
        logic [6:0]  exp_fill;
    } vec_t;

    vec_t vecs[68];

    shift_taps_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .flush        (flush),
        .busy         (busy),
        .sr_shift     (sr_shift),
        .sr_din       (sr_din),
        .sr_tap_one   (sr_tap_one),
        .sr_tap_two   (sr_tap_two),
        .sr_tap_three (sr_tap_three),
        .sr_out       (sr_out),
        .out_win      (out_win),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .fill_count   (fill_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (sr_shift) begin
            sr_mem[0] <= sr_din;
            for (int i = 1; i < 64; i++)
                sr_mem[i] <= sr_mem[i-1];
        end
    end

    assign sr_tap_one   = sr_mem[15];
    assign sr_tap_two   = sr_mem[31];
    assign sr_tap_three = sr_mem[47];
    assign sr_out       = sr_mem[63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic ordy, input logic fl);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        step();
        rst = 1'b0;
    endtask

    task automatic fill_bytes(input logic [7:0] base, input int n, input int flush_at);
        for (int k = 0; k < n; k++) begin
            drive(1'b1, base + 8'(k), 1'b1, k == flush_at);
            @(negedge clk);
            chk("fill_in_ready", in_ready, 1);
            chk("fill_sr_din", sr_din, base + 8'(k));
            step();
            chk("fill_out_valid", out_valid, 0);
            chk("fill_count", fill_count, k + 1);
            chk("fill_busy", busy, 0);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        drive(1'b0, 8'h00, 1'b1, 1'b0);

        for (int i = 0; i < 64; i++)
            vecs[i] = '{1'b1, 8'(i), 1'b1, 1'b1, 1'b0, 32'h0, 7'(i + 1)};
        vecs[64] = '{1'b1, 8'h40, 1'b1, 1'b1, 1'b1, 32'h00102030, 7'd64};
        vecs[65] = '{1'b1, 8'h41, 1'b1, 1'b1, 1'b1, 32'h01112131, 7'd64};
        vecs[66] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 32'h02122232, 7'd64};
        vecs[67] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 32'h0,        7'd64};

        step();
        step();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_sr_shift", sr_shift, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_win", out_win, 32'h0);
        chk("rst_fill_count", fill_count, 0);
        chk("rst_busy", busy, 0);
        step();

        // Fill and streaming table
        for (int i = 0; i < 68; i++) begin
            drive(vecs[i].v, vecs[i].d, vecs[i].ordy, 1'b0);
            @(negedge clk);
            chk("vec_in_ready", in_ready, vecs[i].exp_rdy);
            chk("vec_sr_shift", sr_shift, vecs[i].v && vecs[i].exp_rdy);
            step();
            chk("vec_out_valid", out_valid, vecs[i].exp_ov);
            chk("vec_fill_count", fill_count, vecs[i].exp_fill);
            if (vecs[i].exp_ov)
                chk("vec_out_win", out_win, vecs[i].exp_win);
        end

        // Flush from idle, with a second flush pulse ignored mid-flush
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        @(negedge clk);
        chk("flush_req_sr_shift", sr_shift, 0);
        chk("flush_req_busy", busy, 0);
        step();
        chk("flush_busy_rise", busy, 1);
        for (int k = 0; k < 64; k++) begin
            drive(1'b1, 8'hAA, 1'b1, k == 10);
            @(negedge clk);
            chk("flush_busy", busy, 1);
            chk("flush_sr_shift", sr_shift, 1);
            chk("flush_sr_din", sr_din, 8'h00);
            chk("flush_in_ready", in_ready, 0);
            step();
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        chk("flush_busy_fall", busy, 0);
        chk("flush_fill_count", fill_count, 0);
        chk("flush_out_valid", out_valid, 0);

        // Refill after flush, then backpressure with an ignored flush while pend=1
        fill_bytes(8'h00, 64, -1);
        drive(1'b1, 8'h40, 1'b0, 1'b0);
        @(negedge clk);
        chk("bp_first_in_ready", in_ready, 1);
        step();
        chk("bp_out_valid", out_valid, 1);
        chk("bp_out_win", out_win, 32'h00102030);
        for (int j = 0; j < 4; j++) begin
            drive(1'b1, 8'h41, 1'b0, j == 1);
            @(negedge clk);
            chk("bp_stall_in_ready", in_ready, 0);
            chk("bp_stall_sr_shift", sr_shift, 0);
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_win", out_win, 32'h00102030);
            chk("bp_flush_ignored", busy, 0);
        end
        drive(1'b1, 8'h41, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_release_in_ready", in_ready, 1);
        step();
        chk("bp_win2_valid", out_valid, 1);
        chk("bp_win2", out_win, 32'h01112131);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        @(negedge clk);
        chk("bp_drain_in_ready", in_ready, 1);
        step();
        chk("bp_win3_valid", out_valid, 1);
        chk("bp_win3", out_win, 32'h02122232);
        step();
        chk("bp_empty", out_valid, 0);

        // Reset mid-fill; flush coincident with an accept is ignored
        do_reset();
        fill_bytes(8'hC0, 40, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_fill_count", fill_count, 0);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_busy", busy, 0);
        fill_bytes(8'h40, 64, -1);
        step();
        chk("midrst_win_valid", out_valid, 1);
        chk("midrst_win", out_win, 32'h40506070);
        chk("midrst_fill_full", fill_count, 64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/shift_taps_ctrl.md
Name: shift_taps_ctrl

Overview:
Sequencer for the 8x64 tapped shift register (shift_8x64_taps). Accepts a valid/ready byte stream and drives the register's shift and sr_in inputs. Once 64 bytes have been loaded, it snapshots each new tap window into a registered output with valid/ready backpressure. It also provides a flush command that zero-fills the register and restarts the fill count.

Parameters:
WIDTH, 8, byte width of the shift register.
DEPTH, 64, number of stages; a window is emitted only when fill_count == DEPTH.
FCW, 7, width of fill_count; must be at least clog2(DEPTH+1).

Ports:
clk  in  1  clock; all logic on the rising edge.
rst  in  1  synchronous reset, active-high.
in_data  in  WIDTH  sample byte.
in_valid  in  1  upstream has a byte.
in_ready  out  1  controller accepts in_data this cycle.
flush  in  1  single-cycle request to zero-fill the register.
busy  out  1  high while a flush is in progress.
sr_shift  out  1  to the register's shift input.
sr_din  out  WIDTH  to the register's sr_in input.
sr_tap_one  in  WIDTH  stage 15 (byte accepted 15 shifts ago).
sr_tap_two  in  WIDTH  stage 31.
sr_tap_three  in  WIDTH  stage 47.
sr_out  in  WIDTH  stage 63.
out_win  out  4*WIDTH  packed window: [7:0] tap_one, [15:8] tap_two, [23:16] tap_three, [31:24] sr_out.
out_valid  out  1  out_win holds an unconsumed window.
out_ready  in  1  downstream consumes the window.
fill_count  out  FCW  stages holding live data, saturating at DEPTH.

Behaviour:
- Reset state: state=IDLE, fill_count=0, pend=0, out_valid=0, out_win=0, busy=0, flush_cnt=0.
- Reset does not clear the external register. Stale contents are never emitted because fill_count gates all output.
- State machine has two states, IDLE and FLUSH.
- Output slot: slot_free = !out_valid || out_ready.
- IDLE, acceptance:
  - in_ready = !pend || slot_free.
  - accept = in_valid && in_ready.
  - sr_shift = accept and sr_din = in_data, both combinational in the same cycle.
- IDLE, fill count: on accept, fill_count <= min(fill_count+1, DEPTH).
- IDLE, pend:
  - pend is set on accept when the post-increment fill_count == DEPTH.
  - pend is cleared when a capture occurs.
  - pend set and cleared in the same cycle results in pend=1.
- Capture:
  - A capture occurs when pend && slot_free.
  - It loads out_win from the tap inputs, which reflect the shift clocked one edge earlier, and sets out_valid=1.
  - A concurrent accept in the same cycle is legal; the capture samples the pre-shift taps.
- Latency and throughput: accept at edge N gives out_valid high after edge N+1. Sustained throughput is 1 byte per cycle when out_ready is held high.
- Output handshake: out_valid && out_ready with no capture that cycle results in out_valid <= 0. out_win is stable while out_valid && !out_ready.
- Backpressure: with pend=1 and the output stalled, in_ready=0, the register does not shift, and pend holds.
- FLUSH entry: flush in IDLE with pend=0 and no accept that cycle gives state <= FLUSH, busy <= 1, flush_cnt <= 0.
  - flush with pend=1, or coincident with an accept, is ignored. Callers retry.
- FLUSH operation:
  - in_ready=0, sr_shift=1, sr_din=0 for exactly DEPTH cycles.
  - No captures and no pend.
  - A pending out_valid may still drain.
  - flush while in FLUSH is ignored.
- FLUSH exit: after the DEPTH-th shift, state <= IDLE, busy <= 0, fill_count <= 0.
- Reset mid-flush returns to IDLE immediately; the register contents are then partially zeroed, which is harmless.

Decomposition:
- Package shift_taps_pkg holds: DEPTH, WIDTH, the tap stage indices 15/31/47/63, the out_win field offsets, and the state enum {IDLE, FLUSH}.
- One sub-module, shift_taps_out_reg: the out_win/out_valid holding register with the slot_free logic.

Test Plan:
- Fill: accept bytes 0x00..0x3F back-to-back, out_ready=1 -> no out_valid for the first 63 accepts; one cycle after the 64th, out_win=0x00102030 and fill_count=64.
- Streaming: then accept 0x40, 0x41 -> successive out_win values 0x01112131 and 0x02122232, one per cycle, no bubbles.
- Backpressure: after the fill, drop out_ready for 5 cycles while in_valid=1 -> out_win holds 0x00102030, at most one further byte is accepted, then in_ready=0; on release, windows resume in order with none lost or duplicated.
- Flush: pulse flush when idle -> busy high for exactly 64 cycles, sr_shift=1 and sr_din=0 each cycle, in_ready=0; afterwards fill_count=0 and 64 new bytes are needed before the next out_valid.
- Reset mid-fill: after 40 accepts assert rst for 1 cycle -> fill_count=0, out_valid=0; the next window appears only after 64 further accepts and contains only post-reset bytes.
- Ignored flush: flush asserted with pend=1 or during FLUSH -> no state change, and the busy duration is not extended.
